// File: rtl/shift_seq_if.sv
// Request/response bundle for the shift sequencer: the requester drives the
// master side and the sequencer implements the slave side.
interface shift_seq_if #(
    parameter int n = 32
);
    localparam int SW = $clog2(n);

    logic          start;
    logic [1:0]    op;
    logic [n-1:0]  operand;
    logic [SW-1:0] shamt;
    logic          busy;
    logic          done;
    logic [n-1:0]  result;

    modport master (
        output start, op, operand, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand, shamt,
        output busy, done, result
    );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle SLL/SRL/SRA sequencer, one bit per cycle (IDLE -> SHIFT -> DONE).
// Define SHIFT_SEQ_STEP4_EN to shift by 4 whenever at least 4 positions remain.
module shift_seq #(
    parameter int n = 32
) (
    input  logic        clk,
    input  logic        reset,
    shift_seq_if.slave  bus
);
    localparam int SW = $clog2(n);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [n-1:0]  acc_q, acc_d;
    logic [n-1:0]  result_q, result_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [SW-1:0] step;
    logic [n-1:0]  acc_shifted;

    function automatic logic [n-1:0] shift_by(input logic [n-1:0]  v,
                                              input logic [1:0]    o,
                                              input logic [SW-1:0] amt);
        case (o)
            2'b00:   return v << amt;
            2'b01:   return v >> amt;
            2'b10:   return $unsigned($signed(v) >>> amt);
            default: return v;
        endcase
    endfunction

    always_comb begin
`ifdef SHIFT_SEQ_STEP4_EN
        step = (cnt_q >= SW'(4)) ? SW'(4) : SW'(1);
`else
        step = SW'(1);
`endif
        acc_shifted = shift_by(acc_q, op_q, step);
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d = bus.operand;
                    cnt_d = bus.shamt;
                    op_d  = bus.op;
                    // Nothing to iterate: result is the operand, captured on the same edge.
                    if (bus.shamt == '0 || bus.op == 2'b11) begin
                        state_d  = DONE;
                        result_d = bus.operand;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_shifted;
                cnt_d = cnt_q - step;
                if (cnt_q == step) begin
                    state_d  = DONE;
                    result_d = acc_shifted;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        bus.busy   = (state_q != IDLE);
        bus.done   = (state_q == DONE);
        bus.result = result_q;
    end
endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: expected results and done cycles are queued
// when a request is driven and checked whenever done pulses.
module tb_shift_seq;
    localparam int N = 32;

    typedef struct packed {
        logic [N-1:0] res;
        int unsigned  c0;
        int unsigned  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned last_c0;
    exp_t        sb[$];

    shift_seq_if #(.n(N)) bus ();

    shift_seq #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] model_res(input logic [1:0] o, input logic [N-1:0] v,
                                               input logic [4:0] s);
        case (o)
            2'b00:   return v << s;
            2'b01:   return v >> s;
            2'b10:   return $unsigned($signed(v) >>> s);
            default: return v;
        endcase
    endfunction

    function automatic int unsigned model_lat(input logic [1:0] o, input logic [4:0] s);
        int unsigned k;
        k = (o == 2'b11) ? 0 : int'(s);
`ifdef SHIFT_SEQ_STEP4_EN
        return k / 4 + k % 4 + 1;
`else
        return k + 1;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check_eq("result", 64'(bus.result), 64'(e.res));
                check_eq("latency", 64'(cyc - e.c0), 64'(e.lat));
            end
        end
    end

    // Drive one start cycle; returns at the start of cycle 1.
    task automatic send(input logic [1:0] o, input logic [N-1:0] v, input logic [4:0] s,
                        input logic [N-1:0] er, input bit expect_it);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.operand = v;
        bus.shamt   = s;
        last_c0     = cyc;
        if (expect_it) sb.push_back('{er, cyc, model_lat(o, s)});
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.operand = ~v;
        bus.shamt   = ~s;
    endtask

    task automatic goto_cycle(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        while (bus.busy !== 1'b0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check_eq("idle_timeout", 64'(0), 64'(1));
    endtask

    task automatic pulse_ignored();
        bus.start   = 1'b1;
        bus.op      = 2'b00;
        bus.operand = 32'hFFFF_FFFF;
        bus.shamt   = 5'd4;
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    initial begin
        int unsigned c0, d, p1;
        logic [1:0]   o;
        logic [N-1:0] v;
        logic [4:0]   s;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = '0;
        bus.operand = '0;
        bus.shamt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 64'(bus.busy), 64'(0));
        check_eq("rst_done", 64'(bus.done), 64'(0));
        check_eq("rst_result", 64'(bus.result), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic SLL with per-cycle busy/done trace
        send(2'b00, 32'h1, 5'd2, 32'h4, 1'b1);
        @(negedge clk);
        check_eq("sll_c1_busy", 64'(bus.busy), 64'(1));
        check_eq("sll_c1_done", 64'(bus.done), 64'(0));
        @(posedge clk); @(negedge clk);
        check_eq("sll_c2_busy", 64'(bus.busy), 64'(1));
        check_eq("sll_c2_done", 64'(bus.done), 64'(0));
        @(posedge clk); @(negedge clk);
        check_eq("sll_c3_busy", 64'(bus.busy), 64'(1));
        check_eq("sll_c3_done", 64'(bus.done), 64'(1));
        @(posedge clk); @(negedge clk);
        check_eq("sll_c4_busy", 64'(bus.busy), 64'(0));
        check_eq("sll_c4_done", 64'(bus.done), 64'(0));
        check_eq("sll_hold", 64'(bus.result), 64'(32'h4));
        @(posedge clk); #1;

        // SRA sign fill and SRL of the same operand
        send(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        send(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b1);
        wait_idle();
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("srl_hold", 64'(bus.result), 64'(32'h1));

        // Zero shift and reserved op
        send(2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b1);
        wait_idle();
        send(2'b11, 32'h1234_5678, 5'd7, 32'h1234_5678, 1'b1);
        wait_idle();

        // Start while busy is ignored; start in the cycle after done is accepted
        send(2'b00, 32'h1, 5'd4, 32'h10, 1'b1);
        c0 = last_c0;
        d  = model_lat(2'b00, 5'd4);
        p1 = (d > 2) ? 2 : 1;
        goto_cycle(c0 + p1);
        pulse_ignored();
        if (p1 != d) begin
            goto_cycle(c0 + d);
            pulse_ignored();
        end
        goto_cycle(c0 + d + 1);
        send(2'b00, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFF0, 1'b1);
        wait_idle();

        // Reset mid-operation aborts without a done pulse
        send(2'b00, 32'h1, 5'd20, 32'h0, 1'b0);
        c0 = last_c0;
        goto_cycle(c0 + 5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 64'(bus.busy), 64'(0));
        check_eq("abort_done", 64'(bus.done), 64'(0));
        check_eq("abort_result", 64'(bus.result), 64'(0));
        repeat (30) @(posedge clk);
        #1;
        send(2'b10, 32'hF000_0000, 5'd4, 32'hFF00_0000, 1'b1);
        wait_idle();

        // Back-to-back, each started the cycle after the previous done
        send(2'b01, 32'h0000_0100, 5'd8, 32'h0000_0001, 1'b1);
        wait_idle();
        send(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1);
        wait_idle();

        for (int i = 0; i < 10; i++) begin
            o = 2'($urandom_range(0, 3));
            v = $urandom;
            s = 5'($urandom_range(0, 31));
            send(o, v, s, model_res(o, v, s), 1'b1);
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_empty", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
